// File: rtl/ahb_regbank_slave.sv
// AHB-Lite slave exposing a parametrised bank of 32-bit registers.
// Supports byte/halfword/word writes, pipelined back-to-back transfers,
// programmable wait states and the two-cycle ERROR response. Register
// contents and per-register write strobes are exported flat to the core.
module ahb_regbank_slave #(
    parameter int                     ADDR_WIDTH   = 12,
    parameter int                     NUM_REGS     = 16,
    parameter int                     WAIT_STATES  = 0,
    parameter logic [NUM_REGS*32-1:0] RESET_VALUES = {(NUM_REGS*32){1'b0}},
    parameter logic [NUM_REGS*32-1:0] RO_MASK      = {(NUM_REGS*32){1'b0}}
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic                     hsel,
    input  logic [ADDR_WIDTH-1:0]    haddr,
    input  logic [1:0]               htrans,
    input  logic                     hwrite,
    input  logic [2:0]               hsize,
    input  logic                     hready,
    input  logic [31:0]              hwdata,
    output logic                     hreadyout,
    output logic                     hresp,
    output logic [31:0]              hrdata,
    output logic [NUM_REGS*32-1:0]   regs_q,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Counter preload so that the WAIT state lasts exactly WAIT_STATES cycles.
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    // Little-endian lane enables expanded to a 32-bit bit mask.
    function automatic logic [31:0] lane_mask_f(input logic [2:0] size, input logic [1:0] offs);
        logic [3:0]  lanes;
        logic [31:0] mask;
        case (size)
            3'b000:  lanes = 4'b0001 << offs;
            3'b001:  lanes = 4'b0011 << offs;
            3'b010:  lanes = 4'b1111;
            default: lanes = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{lanes[i]}};
        end
        return mask;
    endfunction

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [2:0]               wait_cnt_r;
    logic [2:0]               wait_cnt_nxt_s;
    logic                     capture_s;
    logic                     accept_s;
    logic                     addr_err_s;
    logic [5:0]               idx_r;
    logic [1:0]               offs_r;
    logic [2:0]               size_r;
    logic                     write_r;
    logic [NUM_REGS*32-1:0]   regs_r;
    logic [NUM_REGS-1:0]      wr_pulse_r;
    logic                     hreadyout_r;
    logic                     hresp_r;
    logic [31:0]              sel_word_s;
    logic [31:0]              hrdata_s;
    logic [31:0]              lane_mask_s;
    logic                     commit_s;
    logic                     unused_s;

    // htrans[0] only separates NONSEQ from SEQ, which are handled identically.
    assign unused_s = htrans[0];

    assign accept_s = hsel & hready & htrans[1];

    // Out-of-range, upper-address, oversize and misaligned accesses all error.
    assign addr_err_s = ({1'b0, haddr[7:2]} >= 7'(NUM_REGS))
                     || ((haddr >> 4'd8) != {ADDR_WIDTH{1'b0}})
                     || (hsize > 3'b010)
                     || ((hsize == 3'b001) && haddr[0])
                     || ((hsize == 3'b010) && (haddr[1:0] != 2'b00));

    // Next-state and wait-counter logic for the transfer sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        capture_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept_s) begin
                    capture_s = 1'b1;
                    if (addr_err_s) begin
                        state_nxt_s = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt_s    = ST_WAIT;
                        wait_cnt_nxt_s = WAIT_LOAD;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 3'd0) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r - 3'd1;
                end
            end
            ST_ERR1: begin
                state_nxt_s = ST_ERR2;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, wait counter and registered handshake outputs.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 3'd0;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            hreadyout_r <= (state_nxt_s != ST_WAIT) && (state_nxt_s != ST_ERR1);
            hresp_r     <= (state_nxt_s == ST_ERR1) || (state_nxt_s == ST_ERR2);
        end
    end

    // Address-phase capture of the accepted transfer.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            idx_r   <= 6'd0;
            offs_r  <= 2'd0;
            size_r  <= 3'd0;
            write_r <= 1'b0;
        end else if (capture_s) begin
            idx_r   <= haddr[7:2];
            offs_r  <= haddr[1:0];
            size_r  <= hsize;
            write_r <= hwrite;
        end else begin
            idx_r   <= idx_r;
            offs_r  <= offs_r;
            size_r  <= size_r;
            write_r <= write_r;
        end
    end

    assign lane_mask_s = lane_mask_f(size_r, offs_r);
    assign commit_s    = (state_r == ST_DATA) && write_r;

    // Register bank update with lane and read-only masking, plus write strobes.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            regs_r     <= RESET_VALUES;
            wr_pulse_r <= {NUM_REGS{1'b0}};
        end else begin
            wr_pulse_r <= {NUM_REGS{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_s && (idx_r == 6'(i))) begin
                    regs_r[i*32 +: 32] <= (regs_r[i*32 +: 32] & ~(lane_mask_s & ~RO_MASK[i*32 +: 32]))
                                        | (hwdata & lane_mask_s & ~RO_MASK[i*32 +: 32]);
                    wr_pulse_r[i]      <= 1'b1;
                end else begin
                    regs_r[i*32 +: 32] <= regs_r[i*32 +: 32];
                end
            end
        end
    end

    // Select the register addressed by the captured index.
    always_comb begin
        sel_word_s = 32'h0000_0000;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_r == 6'(i)) begin
                sel_word_s = regs_r[i*32 +: 32];
            end else begin
                sel_word_s = sel_word_s;
            end
        end
    end

    // Read data is driven only during the completing cycle of a read.
    always_comb begin
        hrdata_s = 32'h0000_0000;
        if ((state_r == ST_DATA) && !write_r) begin
            hrdata_s = sel_word_s;
        end else begin
            hrdata_s = 32'h0000_0000;
        end
    end

    assign hreadyout = hreadyout_r;
    assign hresp     = hresp_r;
    assign hrdata    = hrdata_s;
    assign regs_q    = regs_r;
    assign wr_pulse  = wr_pulse_r;

endmodule

// File: tb/tb_ahb_regbank_slave.sv
// Self-checking bench for ahb_regbank_slave: a transfer-level model predicts
// every cycle's outputs; directed scenarios pin the model with literals, then
// randomized traffic (with occasional resets) is checked against the model.
module tb_ahb_regbank_slave;

    localparam int AW = 12;
    localparam int NR = 16;
    localparam int W  = 2;
    localparam logic [NR*32-1:0] RV = (512'hCAFE_0001 << 96) | (512'h0000_0077 << 64);
    localparam logic [NR*32-1:0] RO = (512'hFFFF_0000 << 160);

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [11:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    logic             hclk = 1'b0;
    logic             hreset, hsel, hwrite, hready;
    logic [AW-1:0]    haddr;
    logic [1:0]       htrans;
    logic [2:0]       hsize;
    logic [31:0]      hwdata;
    logic             hreadyout, hresp;
    logic [31:0]      hrdata;
    logic [NR*32-1:0] regs_q;
    logic [NR-1:0]    wr_pulse;

    ahb_regbank_slave #(
        .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(W),
        .RESET_VALUES(RV), .RO_MASK(RO)
    ) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hready(hready),
        .hwdata(hwdata), .hreadyout(hreadyout), .hresp(hresp),
        .hrdata(hrdata), .regs_q(regs_q), .wr_pulse(wr_pulse)
    );

    always #5 hclk = ~hclk;

    // Model state: register contents and the transfer currently in its data phase.
    logic [31:0] mreg [NR];
    logic [NR-1:0] m_pulse;
    bit          dp_valid, dp_err, dp_wr;
    logic [2:0]  dp_size;
    logic [11:0] dp_addr;
    logic [31:0] dp_wdata;
    int          dp_age;
    xfer_t       xq [$];

    int errors = 0;
    int checks = 0;
    int low_cnt, resp_cnt, pulse_cnt;
    logic [31:0] last_rd;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [511:0] pack_regs();
        logic [511:0] p;
        p = '0;
        for (int i = 0; i < NR; i++) p[i*32 +: 32] = mreg[i];
        return p;
    endfunction

    function automatic bit addr_err(input logic [11:0] a, input logic [2:0] s);
        int idx;
        idx = int'(a[7:2]);
        return (idx >= NR) || (a[11:8] != 4'h0) || (s > 3'd2) ||
               (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mreg[i] = RV[i*32 +: 32];
        m_pulse  = '0;
        dp_valid = 0;
        dp_age   = 0;
    endtask

    task automatic commit(input logic [3:0] r);
        int off;
        off = int'(dp_addr[1:0]);
        for (int b = 0; b < 32; b++) begin
            int lane;
            bit en;
            lane = b / 8;
            en = (dp_size == 3'd0 && lane == off) ||
                 (dp_size == 3'd1 && (lane == off || lane == off + 1)) ||
                 (dp_size == 3'd2);
            if (en && !RO[int'(r)*32 + b]) mreg[r][b] = hwdata[b];
        end
    endtask

    function automatic xfer_t mk(input bit wr, input logic [2:0] size, input logic [11:0] addr, input logic [31:0] d);
        xfer_t x;
        x.sel = 1'b1; x.trans = 2'b10; x.wr = wr; x.size = size; x.addr = addr; x.wdata = d;
        return x;
    endfunction

    // One bus cycle: check this cycle's outputs, drive the next edge, advance the model.
    task automatic step(input bit rst);
        bit completing, exp_rdy, acc;
        logic [31:0] exp_rd, new_wdata;
        logic [NR-1:0] pulse_next;
        logic [5:0] dix;
        xfer_t x;
        @(negedge hclk);
        dix = dp_addr[7:2];
        completing = dp_valid && ((dp_err && dp_age == 1) || (!dp_err && dp_age == W));
        exp_rdy = !dp_valid || completing;
        exp_rd = 32'h0;
        if (completing && !dp_err && !dp_wr) exp_rd = mreg[dix[3:0]];
        chk("hreadyout", hreadyout, exp_rdy);
        chk("hresp", hresp, dp_valid && dp_err);
        chk("hrdata", hrdata, exp_rd);
        chk("wr_pulse", wr_pulse, m_pulse);
        chk("regs_q", regs_q, pack_regs());
        if (hreadyout === 1'b0) low_cnt++;
        if (hresp === 1'b1) resp_cnt++;
        if (wr_pulse !== '0) pulse_cnt++;
        if (completing && !dp_err && !dp_wr) last_rd = hrdata;

        hreset = rst;
        hready = exp_rdy;
        new_wdata = $urandom;
        if (exp_rdy) begin
            if (xq.size() > 0) begin
                x = xq.pop_front();
                hsel = x.sel; htrans = x.trans; hwrite = x.wr;
                hsize = x.size; haddr = x.addr; new_wdata = x.wdata;
            end else begin
                hsel = 1'b0; htrans = 2'b00; hwrite = 1'($urandom);
                hsize = 3'($urandom); haddr = AW'($urandom);
            end
        end
        if (dp_valid && dp_wr && !dp_err) hwdata = dp_wdata;
        else hwdata = $urandom;
        acc = exp_rdy && hsel && htrans[1];

        pulse_next = '0;
        if (rst) begin
            model_reset();
        end else begin
            if (completing && !dp_err && dp_wr) begin
                commit(dix[3:0]);
                pulse_next[dix[3:0]] = 1'b1;
            end
            if (exp_rdy) begin
                if (acc) begin
                    dp_valid = 1; dp_err = addr_err(haddr, hsize); dp_wr = hwrite;
                    dp_size = hsize; dp_addr = haddr; dp_wdata = new_wdata; dp_age = 0;
                end else begin
                    dp_valid = 0;
                end
            end else begin
                dp_age++;
            end
            m_pulse = pulse_next;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((xq.size() > 0 || dp_valid) && n < 200) begin
            step(1'b0);
            n++;
        end
        chk("drain_timeout", (xq.size() > 0 || dp_valid), 1'b0);
        step(1'b0);
    endtask

    function automatic xfer_t rand_xfer();
        xfer_t x;
        int mode;
        logic [5:0] idx;
        logic [1:0] off;
        x.sel   = ($urandom_range(0, 9) != 0);
        x.trans = ($urandom_range(0, 9) < 7) ? {1'b1, 1'($urandom)} : {1'b0, 1'($urandom)};
        x.wr    = 1'($urandom);
        x.size  = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
        x.wdata = $urandom;
        mode    = $urandom_range(0, 9);
        idx     = 6'($urandom_range(0, NR - 1));
        off     = 2'($urandom);
        if (x.size == 3'd1) off[0] = 1'b0;
        if (x.size >= 3'd2) off = 2'b00;
        if (mode == 7) x.addr = 12'($urandom);
        else if (mode == 8) x.addr = {4'h0, 6'($urandom_range(NR, 63)), off};
        else if (mode == 9) x.addr = {4'h0, idx, 2'($urandom)};
        else x.addr = {4'h0, idx, off};
        return x;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
        haddr = '0; hwdata = '0; hready = 1'b1;
        low_cnt = 0; resp_cnt = 0; pulse_cnt = 0; last_rd = '0;
        repeat (2) @(posedge hclk);
        model_reset();
        step(1'b0);
        chk("reset_reg3", regs_q[127:96], 32'hCAFE_0001);

        xq.push_back(mk(1'b0, 3'd2, 12'h00C, 32'h0));
        drain();
        chk("read_reg3", last_rd, 32'hCAFE_0001);
        chk("model_reg3", mreg[3], 32'hCAFE_0001);

        pulse_cnt = 0;
        xq.push_back(mk(1'b1, 3'd0, 12'h002, 32'h00AB_0000));
        drain();
        chk("byte_write", regs_q[31:0], 32'h00AB_0000);
        chk("byte_pulse_cycles", pulse_cnt, 1);
        xq.push_back(mk(1'b1, 3'd1, 12'h000, 32'h0000_1234));
        drain();
        chk("half_write", regs_q[31:0], 32'h00AB_1234);
        chk("model_reg0", mreg[0], 32'h00AB_1234);

        resp_cnt = 0; pulse_cnt = 0;
        xq.push_back(mk(1'b1, 3'd2, 12'h040, 32'hDEAD_BEEF));
        xq.push_back(mk(1'b1, 3'd2, 12'h002, 32'hDEAD_BEEF));
        drain();
        chk("err_resp_cycles", resp_cnt, 4);
        chk("err_no_pulse", pulse_cnt, 0);
        chk("err_reg0_kept", regs_q[31:0], 32'h00AB_1234);

        low_cnt = 0;
        xq.push_back(mk(1'b1, 3'd2, 12'h004, 32'h1111_1111));
        xq.push_back(mk(1'b0, 3'd2, 12'h004, 32'h0));
        drain();
        chk("pipe_read", last_rd, 32'h1111_1111);
        chk("pipe_wait_cycles", low_cnt, 4);

        xq.push_back(mk(1'b1, 3'd2, 12'h014, 32'hFFFF_FFFF));
        drain();
        chk("ro_mask", regs_q[191:160], 32'h0000_FFFF);

        pulse_cnt = 0;
        xq.push_back(mk(1'b1, 3'd2, 12'h008, 32'h0000_0005));
        for (int n = 0; n < 20; n++) begin
            step(1'b0);
            if (dp_valid && dp_wr && dp_age == 1) break;
        end
        step(1'b1);
        step(1'b0);
        step(1'b0);
        chk("rst_mid_reg2", regs_q[95:64], 32'h0000_0077);
        chk("rst_mid_ready", hreadyout, 1'b1);
        chk("rst_mid_no_pulse", pulse_cnt, 0);

        for (int c = 0; c < 3000; c++) begin
            if (xq.size() == 0) xq.push_back(rand_xfer());
            step($urandom_range(0, 299) == 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_regbank_slave.md
Name: ahb_regbank_slave

Overview:
- Parametrised AHB-Lite slave register bank; next generation of the fixed 10-register slave.
- Generic NUM_REGS x 32-bit bank with per-register reset values and read-only masks.
- Adds byte/halfword writes (hsize lanes), htrans qualification, pipelined back-to-back transfers, programmable wait states and the two-cycle ERROR response.
- Sits on the AHB-Lite fabric behind the address decoder; register contents are exported flat to the peripheral core.

Parameters:
- ADDR_WIDTH, 12: haddr width.
- NUM_REGS, 16: number of 32-bit registers, word-aligned from offset 0 (1..64).
- WAIT_STATES, 0: extra data-phase cycles with hreadyout low before completion (0..7).
- RESET_VALUES, all zero: NUM_REGS*32 flat vector; register i reset value is bits [32i+31:32i].
- RO_MASK, all zero: NUM_REGS*32 flat vector; 1 = bit is read-only, and bus writes to it are ignored.

Ports:
- hclk  in  1  bus clock; all logic on rising edge.
- hreset  in  1  synchronous, active-high reset.
- hsel  in  1  slave select.
- haddr  in  ADDR_WIDTH  byte address.
- htrans  in  2  transfer type; only NONSEQ (10) and SEQ (11) start transfers.
- hwrite  in  1  1 = write.
- hsize  in  3  000 = byte, 001 = half, 010 = word; anything larger is an error.
- hready  in  1  bus-wide ready.
- hwdata  in  32  write data, valid in the data phase.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  32  read data.
- regs_q  out  NUM_REGS*32  current register contents, flat.
- wr_pulse  out  NUM_REGS  one-cycle strobe, high in the cycle after a register is written.

Behaviour:
- Interface: one clock, hclk. Reset hreset is synchronous and active-high.
- Reset state:
  - regs = RESET_VALUES
  - state = IDLE
  - hreadyout = 1, hresp = 0, hrdata = 0, wr_pulse = 0
  - Reset asserted mid-transfer aborts it; a pending write is not committed.
- Address-phase accept: hsel & hready & htrans[1] on a rising edge. The slave captures index = haddr[7:2], byte offset haddr[1:0], hsize and hwrite.
- IDLE/BUSY transfers, or hsel = 0: nothing is captured.
  - If a data phase is in progress, it completes normally.
  - Otherwise OKAY with zero wait.
- Error check at accept. An error is flagged for any of:
  - index >= NUM_REGS
  - haddr[ADDR_WIDTH-1:8] != 0
  - hsize > 010
  - misalignment: half with haddr[0] = 1, or word with haddr[1:0] != 0
- States: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: hreadyout = 1.
    - Accept with error -> ERR1.
    - Accept with WAIT_STATES > 0 -> WAIT, counter loaded with WAIT_STATES-1.
    - Otherwise accept -> DATA.
  - WAIT: hreadyout = 0. Counter decrements; at 0 -> DATA.
  - DATA: hreadyout = 1, hresp = 0; the transfer completes this cycle.
    - A new accept this cycle (pipelined) -> ERR1, WAIT or DATA, as from IDLE.
    - Otherwise -> IDLE.
  - ERR1: hreadyout = 0, hresp = 1 -> ERR2.
  - ERR2: hreadyout = 1, hresp = 1. Any accept this cycle is taken as from IDLE; otherwise -> IDLE.
- Write commit:
  - Happens at the rising edge ending DATA, using hwdata sampled on that edge.
  - Byte enables come from hsize/offset, little-endian: byte at lane offset; half at lanes {offset+1, offset}; word at all lanes.
  - Per bit: new = RO_MASK ? old : (lane enabled ? hwdata : old).
  - wr_pulse[index] is high for exactly the next cycle, even if every written bit is read-only.
  - ERROR transfers commit nothing.
- Read:
  - In DATA with hwrite = 0, hrdata = the full 32-bit register (combinational from the captured index), regardless of hsize.
  - Outside read DATA, hrdata = 0.
- Write then read of the same register back-to-back: the read returns the new value.
- No wrap-around: out-of-range addresses always produce ERROR, never alias.
- hburst is not needed; the master supplies every beat's address, and SEQ beats are handled identically to NONSEQ.

Test Plan:
- Reset values: NUM_REGS = 16, RESET_VALUES reg3 = 32'hCAFE_0001. Assert hreset for 2 cycles, then read 0x00C -> hrdata 32'hCAFE_0001, OKAY, hreadyout high in the data phase (WAIT_STATES = 0).
- Byte write: reg0 = 0. Write byte hsize = 000 to haddr 0x002 with hwdata 32'h00AB_0000 -> reg0 = 32'h00AB_0000, wr_pulse[0] high for 1 cycle. A subsequent half write 0x000 with 32'h0000_1234 -> reg0 = 32'h00AB_1234.
- Errors:
  - Write 0x040 (index 16 with NUM_REGS = 16) -> ERR1 (hreadyout 0, hresp 1), then ERR2 (hreadyout 1, hresp 1); no register changes.
  - Word access at 0x002 -> same ERROR sequence.
- Wait states and pipelining: WAIT_STATES = 2. Back-to-back write 0x004 = 32'h1111_1111 then read 0x004 -> each data phase shows hreadyout low for 2 cycles then high; the read returns 32'h1111_1111.
- Read-only mask: RO_MASK reg5 = 32'hFFFF_0000, reset 0. Write 32'hFFFF_FFFF -> reg5 reads 32'h0000_FFFF.
- Reset mid-transfer: WAIT_STATES = 3, write 0x008 = 32'h5, assert hreset in the second wait cycle -> reg2 holds its reset value, state IDLE, hreadyout = 1, wr_pulse never asserted.
